pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter stage for the MIPS fetch path.
- Holds the fetch address and selects the next PC each cycle from these sources, in priority order:
  - exception vector
  - pipeline redirect (branch/jump resolution)
  - hold (stall)
  - return-address-stack prediction
  - sequential increment
- Contains a small circular return-address stack (RAS) for jal/jr $ra prediction. Feeds instruction memory and the IF/ID register.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception.
- RAS_DEPTH, 4, return-address-stack entries; power of two, >= 2.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- stall, in, 1, hold PC and RAS this cycle.
- exc_valid, in, 1, take exception vector.
- redirect_valid, in, 1, load redirect_target.
- redirect_target, in, XLEN, redirect address from EX/MEM.
- call_push, in, 1, current fetch is a call; push pc+4.
- ret_pop, in, 1, current fetch is a return; predict from RAS top.
- pc, out, XLEN, current fetch address.
- pc_plus4, out, XLEN, pc+4, combinational.
- fetch_valid, out, 1, pc is a valid fetch address.
- ras_empty, out, 1, RAS holds no entries.
- misalign_err, out, 1, one-cycle pulse: last redirect target had nonzero bits [1:0].

Behaviour:
- Reset (async, active-high), applied immediately:
  - pc = RESET_VECTOR.
  - fetch_valid = 0, misalign_err = 0.
  - RAS count = 0 and pointer = 0, so ras_empty = 1.
- First rising edge after reset release:
  - fetch_valid -> 1.
  - pc is not advanced, so the first fetched address is RESET_VECTOR.
  - All other inputs are ignored on that edge.
- Thereafter, next-PC priority evaluated at each rising edge (first match wins):
  1. exc_valid: pc <= EXC_VECTOR; RAS cleared (count 0); stall ignored.
  2. redirect_valid: pc <= {redirect_target[XLEN-1:2], 2'b00}; RAS untouched; stall ignored; misalign_err <= |redirect_target[1:0].
  3. stall: pc, RAS and misalign_err=0 all hold; call_push and ret_pop are ignored.
  4. ret_pop with RAS non-empty: pc <= RAS top; pop (count-1, pointer-1 mod RAS_DEPTH).
  5. Otherwise: pc <= pc + 4, with XLEN wrap-around (all-ones-minus-3 wraps to 0).
- misalign_err is 0 on every edge that does not take a redirect.
- RAS pushes: when neither exc_valid, redirect_valid nor stall is asserted, call_push pushes pc_plus4.
- Simultaneous call_push and ret_pop (RAS non-empty):
  - Pop then push.
  - pc <= old top; top entry overwritten with pc_plus4; count unchanged.
- Simultaneous call_push and ret_pop (RAS empty):
  - pc <= pc+4; push performed.
- ret_pop on empty RAS: sequential pc+4; no state change.
- Overflow (push with count == RAS_DEPTH):
  - Circular; oldest entry overwritten; count saturates at RAS_DEPTH.
- Underflow: never possible; guarded by the empty check.
- Latency: one cycle from any input to the pc change; pc_plus4 and ras_empty are combinational from registers.
- Reset asserted mid-operation: immediately returns to the reset state regardless of stall, redirect or exception.

Decomposition:
- Shared package mips_pkg:
  - XLEN default
  - RESET_VECTOR and EXC_VECTOR constants
  - INSTR_BYTES = 4
  - a next-PC-source enum: NPC_EXC, NPC_REDIR, NPC_HOLD, NPC_RAS, NPC_SEQ
- Sub-module pc_ras, parametrised by XLEN and RAS_DEPTH:
  - Inputs: push, pop, push_data, clear.
  - Outputs: top, empty, full.
  - Contains the circular storage, pointer and saturating count.
- pc_unit holds the priority mux, the PC register, fetch_valid and misalign_err.

Test Plan:
- Reset then release, no other inputs:
  - pc = 0x0 for two cycles: fetch_valid 0 -> 1, then pc advances 0x4, 0x8, 0xC.
  - Assert reset at pc=0xC: pc = 0x0 immediately, before the clock edge.
- Stall and redirect:
  - stall=1 for 3 cycles at pc=0x10: pc holds 0x10.
  - stall=1 with redirect_valid=1, target 0x200: pc=0x200 next cycle.
- Call/return with RAS:
  - call_push at pc 0x20 and 0x40 (redirects to 0x100 and 0x300 in between).
  - ret_pop twice: pc = 0x44, then 0x24; ras_empty = 1.
  - A third ret_pop: pc sequential +4.
- Overflow (RAS_DEPTH=4):
  - Push 5 times with returns 0x4, 0x8, 0xC, 0x10, 0x14.
  - Pop 4 times yields 0x14, 0x10, 0xC, 0x8; the 5th pop is sequential.
- Exception:
  - Exception with RAS holding 2 entries and simultaneous redirect_valid: pc = 0x8000_0180; ras_empty = 1.
- Misaligned redirect:
  - Redirect to 0x1006: pc = 0x1004 and misalign_err = 1 for exactly one cycle.
  - Simultaneous call_push and ret_pop with top 0x50 at pc 0x60: pc = 0x50, top becomes 0x64, count unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
//============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS fetch path.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package mips_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;
    localparam int          INSTR_BYTES          = 4;

    // Next-PC source, listed from highest to lowest priority
    typedef enum logic [2:0] {
        NPC_EXC   = 3'd0,
        NPC_REDIR = 3'd1,
        NPC_HOLD  = 3'd2,
        NPC_RAS   = 3'd3,
        NPC_SEQ   = 3'd4
    } npc_src_e;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
//============================================================================
// Module      : pc_ras
// Description : Circular return-address stack with saturating occupancy
//               count. On overflow the oldest entry is silently overwritten.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pc_ras
    import mips_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int RAS_DEPTH = 4             // power of two, >= 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int             PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] MAX_COUNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [XLEN-1:0]  stack [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;      // index of the current top entry
    logic [PTR_W:0]   count;
    logic             pop_ok;
    logic [PTR_W-1:0] wr_idx;

    assign empty  = (count == '0);
    assign full   = (count == MAX_COUNT);
    assign top    = stack[ptr];

    // A pop on an empty stack is meaningless, so it is dropped here too
    assign pop_ok = pop & ~empty;

    // Pop+push replaces the top in place; a plain push goes one slot up
    assign wr_idx = pop_ok ? ptr : ptr + 1'b1;

    // Pointer and occupancy tracking; count saturates because the pointer wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            ptr   <= '0;
            count <= '0;
        end else if (pop_ok && !push) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end else if (push && !pop_ok) begin
            ptr   <= ptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    // Entry storage; contents are only meaningful while count covers them
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            stack[wr_idx] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
//============================================================================
// Module      : pc_unit
// Description : Program-counter stage for the MIPS fetch path. Selects the
//               next PC from exception, redirect, stall, RAS prediction or
//               sequential increment, and owns the return-address stack.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pc_unit
    import mips_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEFAULT),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            exc_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call_push,
    input  logic            ret_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            ras_empty,
    output logic            misalign_err
);

    npc_src_e        npc_src;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_clear;
    logic            ras_full_unused;

    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

    // Priority selection of the next-PC source
    always_comb begin
        npc_src = NPC_SEQ;
        if (exc_valid) begin
            npc_src = NPC_EXC;
        end else if (redirect_valid) begin
            npc_src = NPC_REDIR;
        end else if (stall) begin
            npc_src = NPC_HOLD;
        end else if (ret_pop && !ras_empty) begin
            npc_src = NPC_RAS;
        end
    end

    // The first edge after reset only raises fetch_valid, so RAS activity is
    // gated until the stage is running
    assign ras_clear = fetch_valid && (npc_src == NPC_EXC);
    assign ras_pop   = fetch_valid && (npc_src == NPC_RAS);
    assign ras_push  = fetch_valid && call_push &&
                       ((npc_src == NPC_RAS) || (npc_src == NPC_SEQ));

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused)
    );

    // PC register, fetch-valid flag and one-cycle misalignment pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_VECTOR;
            fetch_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else if (!fetch_valid) begin
            fetch_valid  <= 1'b1;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (npc_src == NPC_REDIR) && (|redirect_target[1:0]);
            case (npc_src)
                NPC_EXC:   pc <= EXC_VECTOR;
                NPC_REDIR: pc <= {redirect_target[XLEN-1:2], 2'b00};
                NPC_HOLD:  pc <= pc;
                NPC_RAS:   pc <= ras_top;
                default:   pc <= pc_plus4;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//============================================================================
// Module      : tb_pc_unit
// Description : Scoreboard bench for pc_unit. Stimulus pushes the expected
//               post-edge outputs; a monitor pops and compares them.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        exc_valid;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        call_push;
    logic        ret_pop;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        ras_empty;
    logic        misalign_err;

    typedef struct packed {
        logic        fv;
        logic [31:0] pc;
        logic        empty;
        logic        mis;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    vectors     = 0;
    int    miscompares = 0;
    logic  checking    = 1'b1;
    event  probe_ev;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h8000_0180),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .exc_valid       (exc_valid),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_push       (call_push),
        .ret_pop         (ret_pop),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .ras_empty       (ras_empty),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples 1 time unit after each rising edge or reset probe
    always begin
        @(posedge clk or probe_ev);
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (fetch_valid !== e.fv || pc !== e.pc || ras_empty !== e.empty ||
                misalign_err !== e.mis || pc_plus4 !== (e.pc + 32'd4)) begin
                miscompares++;
                $display("FAIL %s: got fv=%b pc=%h pc4=%h empty=%b mis=%b, want fv=%b pc=%h pc4=%h empty=%b mis=%b",
                         nm, fetch_valid, pc, pc_plus4, ras_empty, misalign_err,
                         e.fv, e.pc, e.pc + 32'd4, e.empty, e.mis);
            end
        end else if (checking && fetch_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got fv=%b pc=%h with no expectation queued, want none", fetch_valid, pc);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic step(input string nm, input logic rs, input logic st, input logic ex,
                        input logic rv, input logic [31:0] tg, input logic cp, input logic rp,
                        input logic efv, input logic [31:0] epc, input logic eemp, input logic emis);
        @(negedge clk);
        reset           = rs;
        stall           = st;
        exc_valid       = ex;
        redirect_valid  = rv;
        redirect_target = tg;
        call_push       = cp;
        ret_pop         = rp;
        exp_q.push_back('{fv: efv, pc: epc, empty: eemp, mis: emis});
        name_q.push_back(nm);
    endtask

    // Raise reset between edges and check it acts before the next edge
    task automatic probe_reset(input string nm);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back('{fv: 1'b0, pc: 32'h0, empty: 1'b1, mis: 1'b0});
        name_q.push_back(nm);
        #2;
        -> probe_ev;
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        exc_valid       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        call_push       = 1'b0;
        ret_pop         = 1'b0;

        // Reset and release
        step("rst_hold",    1,0,0,0,32'h0,0,0, 0,32'h0,1,0);
        step("first_edge",  0,0,0,0,32'h0,0,0, 1,32'h0,1,0);
        step("seq_4",       0,0,0,0,32'h0,0,0, 1,32'h4,1,0);
        step("seq_8",       0,0,0,0,32'h0,0,0, 1,32'h8,1,0);
        step("seq_c",       0,0,0,0,32'h0,0,0, 1,32'hC,1,0);
        probe_reset("async_rst");
        step("rst_held",    1,0,0,0,32'h0,0,0, 0,32'h0,1,0);
        step("rst_release", 0,0,0,0,32'h0,0,0, 1,32'h0,1,0);
        step("seq_4b",      0,0,0,0,32'h0,0,0, 1,32'h4,1,0);
        step("seq_8b",      0,0,0,0,32'h0,0,0, 1,32'h8,1,0);
        step("seq_cb",      0,0,0,0,32'h0,0,0, 1,32'hC,1,0);
        step("seq_10",      0,0,0,0,32'h0,0,0, 1,32'h10,1,0);

        // Stall and redirect
        for (int i = 0; i < 3; i++)
            step("stall_hold", 0,1,0,0,32'h0,0,0, 1,32'h10,1,0);
        step("stall_redir", 0,1,0,1,32'h200,0,0, 1,32'h200,1,0);

        // Call / return
        step("redir_20",    0,0,0,1,32'h20,0,0,  1,32'h20,1,0);
        step("call_20",     0,0,0,0,32'h0,1,0,   1,32'h24,0,0);
        step("redir_100",   0,0,0,1,32'h100,0,0, 1,32'h100,0,0);
        step("redir_40",    0,0,0,1,32'h40,0,0,  1,32'h40,0,0);
        step("call_40",     0,0,0,0,32'h0,1,0,   1,32'h44,0,0);
        step("redir_300",   0,0,0,1,32'h300,0,0, 1,32'h300,0,0);
        step("ret_1",       0,0,0,0,32'h0,0,1,   1,32'h44,0,0);
        step("ret_2",       0,0,0,0,32'h0,0,1,   1,32'h24,1,0);
        step("ret_empty",   0,0,0,0,32'h0,0,1,   1,32'h28,1,0);

        // Overflow: five pushes into four entries
        step("redir_0",     0,0,0,1,32'h0,0,0,   1,32'h0,1,0);
        for (int i = 1; i <= 5; i++)
            step("ovf_push", 0,0,0,0,32'h0,1,0, 1,32'(4 * i),0,0);
        for (int i = 0; i < 4; i++)
            step("ovf_pop",  0,0,0,0,32'h0,0,1, 1,32'(32'h14 - 4 * i),(i == 3),0);
        step("pop5_seq",    0,0,0,0,32'h0,0,1,   1,32'hC,1,0);

        // Exception beats redirect and stall, clears two RAS entries
        step("call_a",      0,0,0,0,32'h0,1,0,   1,32'h10,0,0);
        step("call_b",      0,0,0,0,32'h0,1,0,   1,32'h14,0,0);
        step("exc",         0,1,1,1,32'h503,1,1, 1,32'h8000_0180,1,0);
        step("post_exc",    0,0,0,0,32'h0,0,0,   1,32'h8000_0184,1,0);

        // Misaligned redirect pulse
        step("misalign",    0,0,0,1,32'h1006,0,0, 1,32'h1004,1,1);
        step("misalign_clr",0,0,0,0,32'h0,0,0,    1,32'h1008,1,0);

        // Simultaneous push and pop
        step("redir_4c",    0,0,0,1,32'h4C,0,0,  1,32'h4C,1,0);
        step("call_4c",     0,0,0,0,32'h0,1,0,   1,32'h50,0,0);
        step("redir_60",    0,0,0,1,32'h60,0,0,  1,32'h60,0,0);
        step("push_pop",    0,0,0,0,32'h0,1,1,   1,32'h50,0,0);
        step("ret_new_top", 0,0,0,0,32'h0,0,1,   1,32'h64,1,0);
        step("pushpop_empty",0,0,0,0,32'h0,1,1,  1,32'h68,0,0);
        step("ret_68",      0,0,0,0,32'h0,0,1,   1,32'h68,1,0);
        step("stall_ignore",0,1,0,0,32'h0,1,1,   1,32'h68,1,0);
        step("seq_6c",      0,0,0,0,32'h0,0,0,   1,32'h6C,1,0);

        // Address wrap-around
        step("redir_top",   0,0,0,1,32'hFFFF_FFFC,0,0, 1,32'hFFFF_FFFC,1,0);
        step("wrap",        0,0,0,0,32'h0,0,0,   1,32'h0,1,0);

        @(negedge clk);
        checking = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
